pic_irq_priority_stage: RTL and testbench
=========================================

Name: pic_irq_priority_stage

Overview:
Upstream neighbour of the 8259 control logic. Holds the Interrupt Request Register (IRR) and In-Service Register (ISR) and performs priority resolution, including rotation. It raises an interrupt request to the control logic and, on INTA-derived strobes, moves the winning IRR bit into the ISR. It supplies highest_priority_ISR, IRR and ISR to the control logic and applies the EOI, AEOI and rotate commands that the control logic decodes from OCW2.

Parameters:
NUM_IRQ, 8, number of interrupt request lines (fixed at 8 for 8259 compatibility)
IDX_W, 3, width of an IR index (log2 NUM_IRQ)

Ports:
clk  input  1  system clock; all state updates on posedge
reset  input  1  synchronous, active-high reset
IR  input  8  raw request lines, synchronous to clk
init  input  1  one-cycle pulse on an ICW1 write; same effect as reset
ltim  input  1  1 = level-triggered, 0 = edge-triggered (ICW1 LTIM)
imr  input  8  interrupt mask (OCW1); 1 = masked
set_isr  input  1  one-cycle pulse at the first INTA (begin_to_set_ISR)
ack_done  input  1  one-cycle pulse at the end of the second INTA
aeoi  input  1  automatic EOI enable (ICW4 AEOI)
eoi_valid  input  1  one-cycle EOI command strobe
eoi_specific  input  1  1 = specific EOI, 0 = non-specific EOI
eoi_level  input  3  target level for a specific EOI
rotate_on_eoi  input  1  rotate priority when an ISR bit is cleared by EOI/AEOI
set_prio  input  1  one-cycle set-priority strobe
prio_level  input  3  level that becomes lowest priority on set_prio
irr  output  8  interrupt request register
isr  output  8  in-service register
int_req  output  1  interrupt request to control logic (drives INT)
vec_idx  output  3  IR index latched at set_isr; used for vector address
highest_priority_ISR  output  3  index of highest-priority set ISR bit; 0 when ISR is empty
isr_any  output  1  1 when any ISR bit is set

Behaviour:
- Reset or init (state on the cycle after):
  - irr = 0, isr = 0, int_req = 0, vec_idx = 0, lowest_prio = 7 (IR0 highest).
  - ir_prev = 8'hFF, so lines already high after reset do not register an edge.
- Priority order: lowest_prio+1 is highest, counting upward mod 8; lowest_prio itself is lowest.
- IRR update, per bit i, every cycle:
  - Edge mode: set on IR[i] & ~ir_prev[i]. Cleared when IR[i] is low, or when bit i is transferred to the ISR.
  - Level mode: irr[i] follows IR[i], except it is cleared in the cycle bit i is transferred.
  - ir_prev <= IR every cycle.
- Candidate = highest-priority bit of irr & ~imr.
- int_req (registered, 1-cycle latency from irr/isr/imr) = a candidate exists AND (isr empty OR candidate priority strictly higher than highest_priority_ISR priority). This is fully-nested mode.
- On set_isr:
  - With a candidate: vec_idx <= candidate, isr[candidate] <= 1, irr[candidate] <= 0.
  - With no candidate (spurious): vec_idx <= 7; isr and irr unchanged.
- On ack_done with aeoi=1: clear isr[vec_idx]. If rotate_on_eoi=1, lowest_prio <= vec_idx.
- On eoi_valid:
  - Non-specific: clear the highest-priority set ISR bit.
  - Specific: clear isr[eoi_level].
  - If rotate_on_eoi=1 and a bit was actually cleared, lowest_prio <= that index.
  - With ISR empty, or the specific target bit already 0, nothing changes, including no rotation.
- On set_prio: lowest_prio <= prio_level. If set_prio and a rotation occur in the same cycle, set_prio wins.
- Simultaneous events in one cycle:
  - EOI and AEOI are evaluated against the pre-update isr.
  - If set_isr targets the same bit that is being cleared, the set wins.
  - An IRR edge on a non-winner bit coinciding with set_isr sets normally.
- highest_priority_ISR and isr_any are combinational from isr and lowest_prio.
- Wrap-around: priority search is circular with no dead level. With lowest_prio = 3, the order is 4,5,6,7,0,1,2,3.

Decomposition:
- Shared package pic_pkg holds:
  - NUM_IRQ and IDX_W constants.
  - EOI command encodings shared with the control logic.
  - A rotate helper function (index <-> relative priority).
- One sub-module, pic_rotating_prio_encoder: combinational. Inputs are an 8-bit request vector and 3-bit lowest_prio; outputs are a 3-bit index and a valid bit. It is instantiated twice, once for the IRR candidate and once for the ISR highest.

Test Plan:
- Reset with IR=8'h01 held high, then IR=8'h00, then IR=8'h01 in edge mode -> no irr bit after reset; irr=8'h01 on the second rising edge; int_req=1 one cycle later.
- IR=8'h60, imr=0, set_isr -> vec_idx=5, isr=8'h20, irr=8'h40. A non-specific EOI -> isr=0; int_req reasserts for IR6.
- isr=8'h04, then IR3 rises -> int_req stays 0. IR1 rises -> int_req=1.
- rotate_on_eoi=1, IR4 served, then a non-specific EOI -> lowest_prio=4. With IR3 and IR5 both pending, set_isr gives vec_idx=5.
- aeoi=1: set_isr then ack_done -> isr returns to 0 without eoi_valid. set_isr with irr&~imr=0 -> vec_idx=7, isr unchanged.
- Level mode, IR2 pulsed high 3 cycles then low -> irr[2] follows the line; specific EOI to level 6 with isr=0 -> no change.

Source files
------------

// File: rtl/pic_pkg.sv
// rtl/pic_pkg.sv - shared constants, OCW2 EOI encodings and rotation helpers for the PIC
package pic_pkg;

    localparam int NUM_IRQ = 8;
    localparam int IDX_W   = 3;

    // OCW2 R/SL/EOI field values, decoded by the control logic
    localparam logic [2:0] OCW2_ROT_AEOI_CLR = 3'b000;
    localparam logic [2:0] OCW2_NS_EOI       = 3'b001;
    localparam logic [2:0] OCW2_NOP          = 3'b010;
    localparam logic [2:0] OCW2_SP_EOI       = 3'b011;
    localparam logic [2:0] OCW2_ROT_AEOI_SET = 3'b100;
    localparam logic [2:0] OCW2_ROT_NS_EOI   = 3'b101;
    localparam logic [2:0] OCW2_SET_PRIO     = 3'b110;
    localparam logic [2:0] OCW2_ROT_SP_EOI   = 3'b111;

    // Relative priority 0 is the highest level, i.e. lowest_prio + 1
    function automatic logic [IDX_W-1:0] idx_to_rel(input logic [IDX_W-1:0] idx,
                                                     input logic [IDX_W-1:0] lowest_prio);
        return idx - lowest_prio - IDX_W'(1);
    endfunction

    function automatic logic [IDX_W-1:0] rel_to_idx(input logic [IDX_W-1:0] rel,
                                                     input logic [IDX_W-1:0] lowest_prio);
        return rel + lowest_prio + IDX_W'(1);
    endfunction

endpackage

// File: rtl/pic_rotating_prio_encoder.sv
// rtl/pic_rotating_prio_encoder.sv - circular priority encoder with a movable lowest level
module pic_rotating_prio_encoder
    import pic_pkg::*;
(
    input  logic [NUM_IRQ-1:0] req,
    input  logic [IDX_W-1:0]   lowest_prio,
    output logic [IDX_W-1:0]   idx,
    output logic               valid
);

    // Scan from lowest to highest relative priority so the last hit wins
    always_comb begin
        idx   = '0;
        valid = 1'b0;
        for (int r = NUM_IRQ - 1; r >= 0; r--) begin
            if (req[rel_to_idx(IDX_W'(r), lowest_prio)]) begin
                idx   = rel_to_idx(IDX_W'(r), lowest_prio);
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/pic_irq_priority_stage.sv
// rtl/pic_irq_priority_stage.sv - IRR/ISR registers, priority resolution, EOI and rotation
module pic_irq_priority_stage
    import pic_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_IRQ-1:0]  IR,
    input  logic                init,
    input  logic                ltim,
    input  logic [NUM_IRQ-1:0]  imr,
    input  logic                set_isr,
    input  logic                ack_done,
    input  logic                aeoi,
    input  logic                eoi_valid,
    input  logic                eoi_specific,
    input  logic [IDX_W-1:0]    eoi_level,
    input  logic                rotate_on_eoi,
    input  logic                set_prio,
    input  logic [IDX_W-1:0]    prio_level,
    output logic [NUM_IRQ-1:0]  irr,
    output logic [NUM_IRQ-1:0]  isr,
    output logic                int_req,
    output logic [IDX_W-1:0]    vec_idx,
    output logic [IDX_W-1:0]    highest_priority_ISR,
    output logic                isr_any
);

    logic [IDX_W-1:0]   lowest_prio;
    logic [NUM_IRQ-1:0] ir_prev;

    logic [IDX_W-1:0]   cand_idx;
    logic               cand_valid;
    logic [IDX_W-1:0]   isr_idx;
    logic               isr_valid;

    logic [NUM_IRQ-1:0] xfer_mask;
    logic [NUM_IRQ-1:0] eoi_clr;
    logic [NUM_IRQ-1:0] aeoi_clr;
    logic [NUM_IRQ-1:0] irr_next;
    logic [NUM_IRQ-1:0] isr_next;
    logic [IDX_W-1:0]   prio_next;
    logic [IDX_W-1:0]   vec_next;
    logic               int_next;

    pic_rotating_prio_encoder u_irr_enc (
        .req         (irr & ~imr),
        .lowest_prio (lowest_prio),
        .idx         (cand_idx),
        .valid       (cand_valid)
    );

    pic_rotating_prio_encoder u_isr_enc (
        .req         (isr),
        .lowest_prio (lowest_prio),
        .idx         (isr_idx),
        .valid       (isr_valid)
    );

    assign highest_priority_ISR = isr_valid ? isr_idx : '0;
    assign isr_any              = isr_valid;

    always_comb begin
        xfer_mask = '0;
        eoi_clr   = '0;
        aeoi_clr  = '0;
        prio_next = lowest_prio;
        vec_next  = vec_idx;

        if (set_isr) begin
            vec_next = cand_valid ? cand_idx : IDX_W'(NUM_IRQ - 1);
            if (cand_valid)
                xfer_mask = NUM_IRQ'(1) << cand_idx;
        end

        // EOI and AEOI both act on the ISR as it stood before this edge
        if (eoi_valid) begin
            if (eoi_specific) begin
                if (isr[eoi_level])
                    eoi_clr = NUM_IRQ'(1) << eoi_level;
            end else if (isr_valid) begin
                eoi_clr = NUM_IRQ'(1) << isr_idx;
            end
        end
        if (ack_done && aeoi)
            aeoi_clr = NUM_IRQ'(1) << vec_idx;

        if (rotate_on_eoi) begin
            if (|aeoi_clr)
                prio_next = vec_idx;
            if (|eoi_clr)
                prio_next = eoi_specific ? eoi_level : isr_idx;
        end
        if (set_prio)
            prio_next = prio_level;

        if (ltim)
            irr_next = IR & ~xfer_mask;
        else
            irr_next = (irr | (IR & ~ir_prev)) & IR & ~xfer_mask;

        // A set on the same bit as a clear keeps the bit in service
        isr_next = (isr & ~(eoi_clr | aeoi_clr)) | xfer_mask;

        int_next = cand_valid &&
                   (!isr_valid || (idx_to_rel(cand_idx, lowest_prio) <
                                   idx_to_rel(isr_idx, lowest_prio)));
    end

    always_ff @(posedge clk) begin
        if (reset || init) begin
            irr         <= '0;
            isr         <= '0;
            int_req     <= 1'b0;
            vec_idx     <= '0;
            lowest_prio <= IDX_W'(NUM_IRQ - 1);
            ir_prev     <= '1;
        end else begin
            irr         <= irr_next;
            isr         <= isr_next;
            int_req     <= int_next;
            vec_idx     <= vec_next;
            lowest_prio <= prio_next;
            ir_prev     <= IR;
        end
    end

endmodule

// File: tb/tb_pic_irq_priority_stage.sv
// tb/tb_pic_irq_priority_stage.sv - table-driven self-checking bench for pic_irq_priority_stage
module tb_pic_irq_priority_stage;

    logic       clk = 1'b0;
    logic       reset, init, ltim, set_isr, ack_done, aeoi;
    logic       eoi_valid, eoi_specific, rotate_on_eoi, set_prio;
    logic [7:0] IR, imr;
    logic [2:0] eoi_level, prio_level;
    logic [7:0] irr, isr;
    logic       int_req, isr_any;
    logic [2:0] vec_idx, highest_priority_ISR;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    pic_irq_priority_stage dut (
        .clk                  (clk),
        .reset                (reset),
        .IR                   (IR),
        .init                 (init),
        .ltim                 (ltim),
        .imr                  (imr),
        .set_isr              (set_isr),
        .ack_done             (ack_done),
        .aeoi                 (aeoi),
        .eoi_valid            (eoi_valid),
        .eoi_specific         (eoi_specific),
        .eoi_level            (eoi_level),
        .rotate_on_eoi        (rotate_on_eoi),
        .set_prio             (set_prio),
        .prio_level           (prio_level),
        .irr                  (irr),
        .isr                  (isr),
        .int_req              (int_req),
        .vec_idx              (vec_idx),
        .highest_priority_ISR (highest_priority_ISR),
        .isr_any              (isr_any)
    );

    // mode bits: ltim, aeoi, rotate_on_eoi
    localparam logic [2:0] L = 3'b001, A = 3'b010, R = 3'b100;
    // op bits: set_isr, ack_done, non-specific EOI, specific EOI, set_prio
    localparam logic [4:0] SET = 5'b00001, ACK = 5'b00010, NS = 5'b00100,
                           SP = 5'b01000, PR = 5'b10000;

    typedef struct {
        logic       rst;
        logic [7:0] ir;
        logic [7:0] imr;
        logic [2:0] mode;
        logic [4:0] op;
        logic [2:0] lvl;
        logic [7:0] e_irr;
        logic [7:0] e_isr;
        logic       e_int;
        logic [2:0] e_vec;
        logic [2:0] e_hp;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t v(logic rst, logic [7:0] ir_v, logic [7:0] imr_v, logic [2:0] mode,
                               logic [4:0] op, logic [2:0] lvl, logic [7:0] e_irr, logic [7:0] e_isr,
                               logic e_int, logic [2:0] e_vec, logic [2:0] e_hp);
        vec_t t;
        t.rst = rst; t.ir = ir_v; t.imr = imr_v; t.mode = mode; t.op = op; t.lvl = lvl;
        t.e_irr = e_irr; t.e_isr = e_isr; t.e_int = e_int; t.e_vec = e_vec; t.e_hp = e_hp;
        return t;
    endfunction

    task automatic check(string name, int n, logic [7:0] act, logic [7:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL step%0d %s: got %h expected %h", n, name, act, exp);
        end
    endtask

    task automatic run_vec(vec_t t, int n);
        reset         = t.rst;
        IR            = t.ir;
        imr           = t.imr;
        ltim          = t.mode[0];
        aeoi          = t.mode[1];
        rotate_on_eoi = t.mode[2];
        set_isr       = t.op[0];
        ack_done      = t.op[1];
        eoi_valid     = t.op[2] | t.op[3];
        eoi_specific  = t.op[3];
        set_prio      = t.op[4];
        eoi_level     = t.lvl;
        prio_level    = t.lvl;
        @(posedge clk);
        #1;
        check("irr", n, irr, t.e_irr);
        check("isr", n, isr, t.e_isr);
        check("int_req", n, {7'd0, int_req}, {7'd0, t.e_int});
        check("vec_idx", n, {5'd0, vec_idx}, {5'd0, t.e_vec});
        check("highest_isr", n, {5'd0, highest_priority_ISR}, {5'd0, t.e_hp});
        check("isr_any", n, {7'd0, isr_any}, {7'd0, |t.e_isr});
    endtask

    initial begin
        reset = 1'b1; init = 1'b0; IR = '0; imr = '0; ltim = 1'b0; aeoi = 1'b0;
        set_isr = 1'b0; ack_done = 1'b0; eoi_valid = 1'b0; eoi_specific = 1'b0;
        eoi_level = '0; rotate_on_eoi = 1'b0; set_prio = 1'b0; prio_level = '0;
        #1;

        // edge mode: line held through reset registers no edge
        tbl.push_back(v(1, 8'h01, 8'h00, 0, 0,  0, 8'h00, 8'h00, 0, 0, 0));
        tbl.push_back(v(0, 8'h01, 8'h00, 0, 0,  0, 8'h00, 8'h00, 0, 0, 0));
        tbl.push_back(v(0, 8'h00, 8'h00, 0, 0,  0, 8'h00, 8'h00, 0, 0, 0));
        tbl.push_back(v(0, 8'h01, 8'h00, 0, 0,  0, 8'h01, 8'h00, 0, 0, 0));
        tbl.push_back(v(0, 8'h01, 8'h00, 0, 0,  0, 8'h01, 8'h00, 1, 0, 0));
        // IR5/IR6, serve IR5, non-specific EOI
        tbl.push_back(v(1, 8'h00, 8'h00, 0, 0,  0, 8'h00, 8'h00, 0, 0, 0));
        tbl.push_back(v(0, 8'h00, 8'h00, 0, 0,  0, 8'h00, 8'h00, 0, 0, 0));
        tbl.push_back(v(0, 8'h60, 8'h00, 0, 0,  0, 8'h60, 8'h00, 0, 0, 0));
        tbl.push_back(v(0, 8'h60, 8'h00, 0, 0,  0, 8'h60, 8'h00, 1, 0, 0));
        tbl.push_back(v(0, 8'h60, 8'h00, 0, SET, 0, 8'h40, 8'h20, 1, 5, 5));
        tbl.push_back(v(0, 8'h60, 8'h00, 0, 0,  0, 8'h40, 8'h20, 0, 5, 5));
        tbl.push_back(v(0, 8'h60, 8'h00, 0, NS, 0, 8'h40, 8'h00, 0, 5, 0));
        tbl.push_back(v(0, 8'h60, 8'h00, 0, 0,  0, 8'h40, 8'h00, 1, 5, 0));
        // fully nested: IR3 blocked by IR2 in service, IR1 preempts
        tbl.push_back(v(1, 8'h00, 8'h00, 0, 0,  0, 8'h00, 8'h00, 0, 0, 0));
        tbl.push_back(v(0, 8'h00, 8'h00, 0, 0,  0, 8'h00, 8'h00, 0, 0, 0));
        tbl.push_back(v(0, 8'h04, 8'h00, 0, 0,  0, 8'h04, 8'h00, 0, 0, 0));
        tbl.push_back(v(0, 8'h04, 8'h00, 0, SET, 0, 8'h00, 8'h04, 1, 2, 2));
        tbl.push_back(v(0, 8'h0C, 8'h00, 0, 0,  0, 8'h08, 8'h04, 0, 2, 2));
        tbl.push_back(v(0, 8'h0C, 8'h00, 0, 0,  0, 8'h08, 8'h04, 0, 2, 2));
        tbl.push_back(v(0, 8'h0E, 8'h00, 0, 0,  0, 8'h0A, 8'h04, 0, 2, 2));
        tbl.push_back(v(0, 8'h0E, 8'h00, 0, 0,  0, 8'h0A, 8'h04, 1, 2, 2));
        // rotate on non-specific EOI of IR4, then IR5 beats IR3
        tbl.push_back(v(1, 8'h00, 8'h00, 0, 0,  0, 8'h00, 8'h00, 0, 0, 0));
        tbl.push_back(v(0, 8'h00, 8'h00, R, 0,  0, 8'h00, 8'h00, 0, 0, 0));
        tbl.push_back(v(0, 8'h10, 8'h00, R, 0,  0, 8'h10, 8'h00, 0, 0, 0));
        tbl.push_back(v(0, 8'h10, 8'h00, R, SET, 0, 8'h00, 8'h10, 1, 4, 4));
        tbl.push_back(v(0, 8'h10, 8'h00, R, NS, 0, 8'h00, 8'h00, 0, 4, 0));
        tbl.push_back(v(0, 8'h38, 8'h00, R, 0,  0, 8'h28, 8'h00, 0, 4, 0));
        tbl.push_back(v(0, 8'h38, 8'h00, R, SET, 0, 8'h08, 8'h20, 1, 5, 5));
        tbl.push_back(v(0, 8'h38, 8'h00, R, 0,  0, 8'h08, 8'h20, 0, 5, 5));
        // AEOI, then spurious acknowledge
        tbl.push_back(v(1, 8'h00, 8'h00, 0, 0,  0, 8'h00, 8'h00, 0, 0, 0));
        tbl.push_back(v(0, 8'h00, 8'h00, A, 0,  0, 8'h00, 8'h00, 0, 0, 0));
        tbl.push_back(v(0, 8'h02, 8'h00, A, 0,  0, 8'h02, 8'h00, 0, 0, 0));
        tbl.push_back(v(0, 8'h02, 8'h00, A, SET, 0, 8'h00, 8'h02, 1, 1, 1));
        tbl.push_back(v(0, 8'h02, 8'h00, A, ACK, 0, 8'h00, 8'h00, 0, 1, 0));
        tbl.push_back(v(0, 8'h02, 8'h00, A, SET, 0, 8'h00, 8'h00, 0, 7, 0));
        // level mode follows the line; specific EOI on empty ISR is a no-op
        tbl.push_back(v(1, 8'h00, 8'h00, 0, 0,  0, 8'h00, 8'h00, 0, 0, 0));
        tbl.push_back(v(0, 8'h00, 8'h00, L, 0,  0, 8'h00, 8'h00, 0, 0, 0));
        tbl.push_back(v(0, 8'h04, 8'h00, L, 0,  0, 8'h04, 8'h00, 0, 0, 0));
        tbl.push_back(v(0, 8'h04, 8'h00, L, 0,  0, 8'h04, 8'h00, 1, 0, 0));
        tbl.push_back(v(0, 8'h04, 8'h00, L, 0,  0, 8'h04, 8'h00, 1, 0, 0));
        tbl.push_back(v(0, 8'h00, 8'h00, L, 0,  0, 8'h00, 8'h00, 1, 0, 0));
        tbl.push_back(v(0, 8'h00, 8'h00, L, SP, 6, 8'h00, 8'h00, 0, 0, 0));

        for (int i = 0; i < tbl.size(); i++)
            run_vec(tbl[i], i);

        // wrap-around with lowest=3, set_prio beating a same-cycle rotation,
        // then set and clear of one ISR bit in the same cycle
        run_vec(v(1, 8'h00, 8'h00, 0, 0,       0, 8'h00, 8'h00, 0, 0, 0), 100);
        run_vec(v(0, 8'h00, 8'h00, 0, 0,       0, 8'h00, 8'h00, 0, 0, 0), 101);
        run_vec(v(0, 8'h81, 8'h00, 0, PR,      3, 8'h81, 8'h00, 0, 0, 0), 102);
        run_vec(v(0, 8'h81, 8'h00, 0, SET,     0, 8'h01, 8'h80, 1, 7, 7), 103);
        run_vec(v(0, 8'h83, 8'h00, R, NS | PR, 0, 8'h03, 8'h00, 0, 7, 0), 104);
        run_vec(v(0, 8'h83, 8'h00, 0, SET,     0, 8'h01, 8'h02, 1, 1, 1), 105);
        run_vec(v(0, 8'h02, 8'h00, L, 0,       0, 8'h02, 8'h02, 0, 1, 1), 106);
        run_vec(v(0, 8'h02, 8'h00, L, SET | SP, 1, 8'h00, 8'h02, 0, 1, 1), 107);

        // masked request: spurious acknowledge, then unmask raises int_req
        run_vec(v(1, 8'h00, 8'h00, 0, 0,   0, 8'h00, 8'h00, 0, 0, 0), 110);
        run_vec(v(0, 8'h00, 8'h00, 0, 0,   0, 8'h00, 8'h00, 0, 0, 0), 111);
        run_vec(v(0, 8'h10, 8'h10, 0, 0,   0, 8'h10, 8'h00, 0, 0, 0), 112);
        run_vec(v(0, 8'h10, 8'h10, 0, SET, 0, 8'h10, 8'h00, 0, 7, 0), 113);
        run_vec(v(0, 8'h10, 8'h00, 0, 0,   0, 8'h10, 8'h00, 1, 7, 0), 114);

        // init behaves like reset
        run_vec(v(0, 8'h10, 8'h00, 0, SET, 0, 8'h00, 8'h10, 1, 4, 4), 115);
        init = 1'b1;
        @(posedge clk);
        #1;
        init = 1'b0;
        check("init_isr", 116, isr, 8'h00);
        check("init_vec", 116, {5'd0, vec_idx}, 8'h00);
        run_vec(v(0, 8'h10, 8'h00, 0, 0,   0, 8'h00, 8'h00, 0, 0, 0), 117);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
